// File: rtl/uart_8250_pkg.sv
// Shared constants for the 8250-compatible register file: offsets, bit
// positions, IIR identification codes and reset values.
package uart_8250_pkg;

  localparam logic [2:0] OFF_RBR_THR = 3'd0;
  localparam logic [2:0] OFF_IER     = 3'd1;
  localparam logic [2:0] OFF_IIR_FCR = 3'd2;
  localparam logic [2:0] OFF_LCR     = 3'd3;
  localparam logic [2:0] OFF_MCR     = 3'd4;
  localparam logic [2:0] OFF_LSR     = 3'd5;
  localparam logic [2:0] OFF_MSR     = 3'd6;
  localparam logic [2:0] OFF_SCR     = 3'd7;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam int IER_ERBFI = 0;
  localparam int IER_ETBEI = 1;
  localparam int IER_ELSI  = 2;

  localparam int MCR_DTR  = 0;
  localparam int MCR_RTS  = 1;
  localparam int MCR_OUT1 = 2;
  localparam int MCR_OUT2 = 3;
  localparam int MCR_LOOP = 4;

  localparam logic [3:0] IIR_NONE = 4'h1;
  localparam logic [3:0] IIR_RLS  = 4'h6;
  localparam logic [3:0] IIR_RDA  = 4'h4;
  localparam logic [3:0] IIR_THRE = 4'h2;

  localparam logic [7:0] LSR_RST = 8'h60;

endpackage

// File: rtl/uart_8250_iir.sv
// Interrupt identification priority encoder: line status, then receive data,
// then transmitter-empty.
import uart_8250_pkg::*;

module uart_8250_iir (
  input  logic       oe,
  input  logic       dr,
  input  logic       thre_ip,
  input  logic [3:0] ier,
  output logic [3:0] iir_id,
  output logic       irq
);

  always_comb begin
    iir_id = IIR_NONE;
    if (oe && ier[IER_ELSI])
      iir_id = IIR_RLS;
    else if (dr && ier[IER_ERBFI])
      iir_id = IIR_RDA;
    else if (thre_ip && ier[IER_ETBEI])
      iir_id = IIR_THRE;
  end

  assign irq = ~iir_id[0];

endmodule

// File: rtl/uart_8250.sv
// Wishbone classic slave exposing an 8250/16550 register file; transmitted
// bytes loop straight back into the receive buffer.
import uart_8250_pkg::*;

module uart_8250 #(
  parameter logic [31:0] BASE_ADDR = 32'h1250_0000
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        WE_I,
  input  logic [3:0]  SEL_I,
  input  logic        STB_I,
  output logic        ACK_O,
  input  logic        CYC_I,
  output logic        INT_O
);

  logic [3:0] ier;
  logic [7:0] lcr;
  logic [4:0] mcr;
  logic [7:0] dll, dlm, scr, rbr;
  logic       fifo_en, thre_ip, dr, oe;

  logic       hit, wr, rd, dlab;
  logic [2:0] off;
  logic [3:0] iir_id;
  logic [7:0] lsr, msr, iir, rdata;
  logic [3:0] unused_sel;

  assign unused_sel = SEL_I;
  assign hit   = (ADR_I[31:3] == BASE_ADDR[31:3]);
  assign off   = ADR_I[2:0];
  assign ACK_O = CYC_I & STB_I & hit;
  assign wr    = ACK_O & WE_I;
  assign rd    = ACK_O & ~WE_I;
  assign dlab  = lcr[7];

  assign lsr = LSR_RST | {6'b0, oe, dr};
  assign msr = mcr[MCR_LOOP] ? {mcr[MCR_OUT2], mcr[MCR_OUT1], mcr[MCR_DTR], mcr[MCR_RTS], 4'b0}
                             : 8'h00;
  assign iir = {fifo_en, fifo_en, 2'b00, iir_id};

  uart_8250_iir u_iir (
    .oe      (oe),
    .dr      (dr),
    .thre_ip (thre_ip),
    .ier     (ier),
    .iir_id  (iir_id),
    .irq     (INT_O)
  );

  always_comb begin
    rdata = 8'h00;
    case (off)
      OFF_RBR_THR: rdata = dlab ? dll : rbr;
      OFF_IER:     rdata = dlab ? dlm : {4'b0, ier};
      OFF_IIR_FCR: rdata = iir;
      OFF_LCR:     rdata = lcr;
      OFF_MCR:     rdata = {3'b0, mcr};
      OFF_LSR:     rdata = lsr;
      OFF_MSR:     rdata = msr;
      OFF_SCR:     rdata = scr;
      default:     rdata = 8'h00;
    endcase
  end

  assign DAT_O = hit ? {24'b0, rdata} : 32'b0;

  // thre_ip is only ever set while ETBEI is (or is becoming) 1 and is cleared
  // whenever ETBEI is written 0, so it can never be pending with ETBEI=0.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      ier     <= '0;
      lcr     <= '0;
      mcr     <= '0;
      dll     <= '0;
      dlm     <= '0;
      scr     <= '0;
      rbr     <= '0;
      fifo_en <= 1'b0;
      thre_ip <= 1'b0;
      dr      <= 1'b0;
      oe      <= 1'b0;
    end else if (wr) begin
      case (off)
        OFF_RBR_THR:
          if (dlab) dll <= DAT_I[7:0];
          else begin
            rbr <= DAT_I[7:0];
            dr  <= 1'b1;
            if (dr) oe <= 1'b1;
            if (ier[IER_ETBEI]) thre_ip <= 1'b1;
          end
        OFF_IER:
          if (dlab) dlm <= DAT_I[7:0];
          else begin
            ier <= DAT_I[3:0];
            if (!DAT_I[IER_ETBEI])     thre_ip <= 1'b0;
            else if (!ier[IER_ETBEI])  thre_ip <= 1'b1;
          end
        OFF_IIR_FCR: begin
          fifo_en <= DAT_I[0];
          if (DAT_I[1]) begin
            dr  <= 1'b0;
            rbr <= 8'h00;
          end
        end
        OFF_LCR: lcr <= DAT_I[7:0];
        OFF_MCR: mcr <= DAT_I[4:0];
        OFF_SCR: scr <= DAT_I[7:0];
        default: ;
      endcase
    end else if (rd) begin
      case (off)
        OFF_RBR_THR: if (!dlab) dr <= 1'b0;
        OFF_IIR_FCR: if (iir_id == IIR_THRE) thre_ip <= 1'b0;
        OFF_LSR:     oe <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_8250.sv
// Directed-vector bench for uart_8250 with hand-computed expected values.
module tb_uart_8250;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] ADR_I = '0;
  logic [31:0] DAT_I = '0;
  logic [31:0] DAT_O;
  logic        WE_I  = 1'b0;
  logic [3:0]  SEL_I = 4'h1;
  logic        STB_I = 1'b0;
  logic        ACK_O;
  logic        CYC_I = 1'b0;
  logic        INT_O;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] B = 32'h1250_0000;

  uart_8250 dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O),
    .WE_I(WE_I), .SEL_I(SEL_I), .STB_I(STB_I), .ACK_O(ACK_O), .CYC_I(CYC_I),
    .INT_O(INT_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample ack/data just before the commit edge.
  task automatic xfer(input logic [31:0] a, input logic we, input logic [31:0] d,
                      output logic [31:0] rdat, output logic ack);
    @(negedge CLK_I);
    ADR_I = a; DAT_I = d; WE_I = we; CYC_I = 1'b1; STB_I = 1'b1;
    #1;
    rdat = DAT_O;
    ack  = ACK_O;
    @(posedge CLK_I);
    #1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [7:0] d);
    logic [31:0] r; logic k;
    xfer(a, 1'b1, {24'h0, d}, r, k);
    chk({tag, ".ack"}, {31'b0, k}, 32'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [7:0] exp);
    logic [31:0] r; logic k;
    xfer(a, 1'b0, 32'h0, r, k);
    chk({tag, ".ack"}, {31'b0, k}, 32'd1);
    chk(tag, r, {24'h0, exp});
  endtask

  task automatic miss(input string tag, input logic [31:0] a, input logic we);
    logic [31:0] r; logic k;
    xfer(a, we, 32'hFF, r, k);
    chk({tag, ".ack"}, {31'b0, k}, 32'd0);
    chk({tag, ".dat"}, r, 32'd0);
  endtask

  task automatic chk_int(input string tag, input logic exp);
    @(negedge CLK_I);
    chk(tag, {31'b0, INT_O}, {31'b0, exp});
  endtask

  initial begin
    repeat (3) @(posedge CLK_I);
    #1 RST_I = 1'b1;

    rd("rst.lcr", B + 3, 8'h00);
    rd("rst.lsr", B + 5, 8'h60);
    rd("rst.iir", B + 2, 8'h01);
    rd("rst.msr", B + 6, 8'h00);
    chk_int("rst.int", 1'b0);

    wr("ier.w", B + 1, 8'h1D);
    rd("ier.r", B + 1, 8'h0D);
    wr("fcr.w", B + 2, 8'h91);
    rd("iir.fifo", B + 2, 8'hC1);

    wr("lcr.w", B + 3, 8'hAD);
    rd("lcr.r", B + 3, 8'hAD);
    wr("dll.w", B + 0, 8'h34);
    wr("dlm.w", B + 1, 8'h12);
    rd("dll.r", B + 0, 8'h34);
    rd("dlm.r", B + 1, 8'h12);
    rd("scr.r0", B + 7, 8'h00);

    wr("lcr.w2", B + 3, 8'h03);
    rd("ier.dlab0", B + 1, 8'h0D);
    wr("ier.w1", B + 1, 8'h01);
    wr("thr.w", B + 0, 8'h5A);
    chk_int("rda.int", 1'b1);
    rd("rda.iir", B + 2, 8'hC4);
    rd("rda.lsr", B + 5, 8'h61);
    rd("rbr.r", B + 0, 8'h5A);
    chk_int("rda.int0", 1'b0);
    rd("rda.lsr0", B + 5, 8'h60);

    wr("ier.w5", B + 1, 8'h05);
    wr("thr.a", B + 0, 8'h11);
    wr("thr.b", B + 0, 8'h22);
    rd("oe.iir", B + 2, 8'hC6);
    rd("oe.lsr", B + 5, 8'h63);
    rd("oe.lsr2", B + 5, 8'h61);
    rd("oe.iir2", B + 2, 8'hC4);
    rd("oe.rbr", B + 0, 8'h22);

    wr("thr.c", B + 0, 8'h77);
    wr("fcr.clr", B + 2, 8'h03);
    rd("fcr.lsr", B + 5, 8'h60);
    rd("fcr.rbr", B + 0, 8'h00);
    rd("fcr.iir", B + 2, 8'hC1);
    wr("fcr.off", B + 2, 8'h00);
    rd("fcr.iir0", B + 2, 8'h01);

    wr("scr.w", B + 7, 8'hA5);
    miss("miss1", 32'h1250_0010, 1'b1);
    miss("miss2", 32'h1256_0002, 1'b0);
    miss("miss3", 32'hF250_0005, 1'b1);
    miss("miss4", 32'h1250_0017, 1'b1);
    miss("miss5", 32'h0250_0003, 1'b1);
    rd("miss.scr", B + 7, 8'hA5);
    rd("miss.lcr", B + 3, 8'h03);

    wr("mcr.w", B + 4, 8'hFF);
    rd("mcr.r", B + 4, 8'h1F);
    rd("msr.lp", B + 6, 8'hF0);
    wr("mcr.w2", B + 4, 8'h19);
    rd("msr.lp2", B + 6, 8'hA0);
    wr("mcr.w3", B + 4, 8'h0F);
    rd("msr.nolp", B + 6, 8'h00);
    wr("lsr.w", B + 5, 8'hFF);
    rd("lsr.ro", B + 5, 8'h60);

    wr("ier.thre", B + 1, 8'h02);
    chk_int("thre.int", 1'b1);
    rd("thre.iir", B + 2, 8'h02);
    rd("thre.iir2", B + 2, 8'h01);
    wr("thre.thr", B + 0, 8'h00);
    rd("thre.lsr", B + 5, 8'h61);
    wr("ier.both", B + 1, 8'h03);
    rd("thre.rda", B + 2, 8'h04);
    rd("thre.rbr", B + 0, 8'h00);
    rd("thre.pend", B + 2, 8'h02);
    wr("ier.off", B + 1, 8'h00);
    wr("ier.on", B + 1, 8'h02);
    rd("thre.rearm", B + 2, 8'h02);
    wr("ier.off2", B + 1, 8'h00);
    rd("thre.clr", B + 2, 8'h01);
    chk_int("thre.int0", 1'b0);

    // Reset asserted during a bus write: reset must win.
    @(negedge CLK_I);
    RST_I = 1'b0;
    ADR_I = B + 7; DAT_I = 32'h55; WE_I = 1'b1; CYC_I = 1'b1; STB_I = 1'b1;
    @(posedge CLK_I);
    #1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; RST_I = 1'b1;
    rd("rstw.scr", B + 7, 8'h00);
    rd("rstw.lcr", B + 3, 8'h00);
    rd("rstw.mcr", B + 4, 8'h00);
    rd("rstw.iir", B + 2, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/uart_8250.md
Name: uart_8250

Overview:
- Wishbone classic slave implementing an 8250/16550-compatible UART register file (byte-wide, register shift 0) at a fixed base address in the SoC memory map.
- This revision has no serial pins: THR writes loop back internally into RBR.
- Provides the register map, DLAB banking, line/modem status, IIR priority encoding and an interrupt output to the CPU.

Parameters:
- BASE_ADDR, 32'h1250_0000, base of the 8-byte register window (must be 8-byte aligned).

Ports:
- CLK_I  in  1  system clock; all state updates on the rising edge.
- RST_I  in  1  synchronous reset, active-low.
- ADR_I  in  32  Wishbone byte address.
- DAT_I  in  32  write data; only [7:0] used.
- DAT_O  out  32  read data; [31:8] always 0.
- WE_I  in  1  1 = write, 0 = read.
- SEL_I  in  4  byte select; ignored, since registers are addressed by byte address with data on lane 0.
- STB_I  in  1  strobe.
- ACK_O  out  1  transfer acknowledge.
- CYC_I  in  1  bus cycle valid.
- INT_O  out  1  interrupt request, active-high.

Behaviour:
- Decode: hit = (ADR_I[31:3] == BASE_ADDR[31:3]); off = ADR_I[2:0]. Example: 0x1250_0010, 0x1250_00A0 and 0x0250_0000 are misses.
- Handshake: ACK_O = CYC_I & STB_I & hit, combinational, giving zero-wait-state single-cycle transfers.
  - Writes commit at the CLK_I edge where ACK_O=1.
  - Read side effects also apply at that edge.
  - DAT_O is combinational from off; DAT_O=0 when not hit.
  - On a miss: no ACK, no state change.
- Map (DLAB = LCR[7]):
  - off0: DLAB=0 read RBR / write THR; DLAB=1 DLL (R/W).
  - off1: DLAB=0 IER (bits[3:0] writable, [7:4] read 0); DLAB=1 DLM (R/W).
  - off2: read IIR / write FCR.
  - off3: LCR (R/W, 8 bits).
  - off4: MCR (bits[4:0] writable, [7:5] read 0).
  - off5: LSR (read-only; writes ignored).
  - off6: MSR (read-only; writes ignored).
  - off7: SCR (R/W).
- THR write: RBR <= DAT_I[7:0]; LSR.DR <= 1; if DR was already 1, LSR.OE <= 1. LSR.THRE (bit5) and TEMT (bit6) stay 1 because transmission is instantaneous.
- RBR read: clears DR.
- LSR read: clears OE (and BI/FE/PE, which are always 0).
- FCR write:
  - bit0 stored as fifo_en; IIR[7:6] = {fifo_en, fifo_en}.
  - bit1 = 1 clears DR and RBR.
  - Bits 2, 3, 7:6 accepted with no effect.
- MSR: reads 0 unless MCR[4] (loop) = 1; then MSR[7:4] = {MCR[3], MCR[2], MCR[0], MCR[1]} and MSR[3:0] = 0.
- THRE interrupt pending (thre_ip):
  - Set on the edge after a THR write.
  - Set when an IER write takes ETBEI from 0 to 1.
  - Cleared by an IIR read that returns ID 0x2.
  - Cleared when ETBEI = 0.
- IIR[3:0], highest priority first:
  - 0x6 when OE & IER[2].
  - 0x4 when DR & IER[0].
  - 0x2 when thre_ip & IER[1].
  - Otherwise 0x1 (no interrupt).
  - IIR[5:4] = 0.
- INT_O = ~IIR[0], combinational.
- Reset (RST_I=0 at an edge): IER=0, LCR=0, MCR=0, DLL=0, DLM=0, SCR=0, RBR=0, fifo_en=0, thre_ip=0, DR=0, OE=0.
  - Resulting reads: LSR=0x60, MSR=0x00, IIR=0x01, INT_O=0.
  - Reset wins over a simultaneous bus write.
- Simultaneous events: a THR write and an RBR read in the same cycle cannot occur (single port). A FCR[1] clear wins over a pending DR.

Decomposition:
- Shared package uart_8250_pkg holds:
  - Register offset constants (RBR_THR=0 ... SCR=7).
  - LSR, IER and MCR bit indices.
  - IIR ID codes (NONE=1, RLS=6, RDA=4, THRE=2).
  - Reset constants (LSR_RST=8'h60).
- One natural sub-module: uart_8250_iir, a combinational priority encoder producing IIR[3:0] and INT_O from the status, IER and thre_ip inputs.

Test Plan:
- Reset with RST_I=0, then read off3, off5, off2 -> 0x00, 0x60, 0x01; INT_O=0.
- Write 0x1250_0001 <= 0x1D, write 0x1250_0002 <= 0x91, read 0x1250_0002 -> 0xC1; each access has ACK_O=1 in the same cycle.
- Write 0x1250_0003 <= 0xAD, read back -> 0xAD; DLAB=1, so off0/off1 access DLL/DLM: write 0x34/0x12, read back 0x34/0x12, SCR unaffected.
- LCR=0x03, IER=0x01, write THR 0x5A -> INT_O=1, IIR=0xC4 or 0x04 per fifo_en, LSR=0x61; read RBR -> 0x5A, then INT_O=0 and LSR=0x60.
- Two THR writes without a read, IER=0x05 -> IIR ID 0x6 and LSR bit1=1; LSR read clears OE and IIR ID becomes 0x4.
- Misses: accesses to 0x1250_0010, 0x1256_0002 and 0xF250_0005 -> ACK_O=0, DAT_O=0, no register change. A THRE check: IER write of 0x02 -> IIR ID 0x2; after an IIR read -> 0x1.
